controlador_fir: RTL

CONTROLADOR_FIR -- requirements
Module: controlador_fir

---
 rtl/filtros_defs.sv | 14 +
 rtl/contador_indice.sv | 42 ++++
 rtl/controlador_fir.sv | 90 +++++++++
 3 files changed

// File: rtl/filtros_defs.sv
// Shared definitions for the FIR controller: default filter size and FSM state encodings.
package filtros_defs;

    localparam int NUM_COEFICIENTES_DEF = 8;
    localparam int BITS_INDICE_DEF      = 3;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        LIMPIAR  = 2'd1,
        ACUMULAR = 2'd2,
        ENTREGAR = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_indice.sv
// Tap index counter: synchronous clear, enable, terminal count at NUM_COEFICIENTES-1.
module contador_indice
    import filtros_defs::*;
#(
    parameter int NUM_COEFICIENTES = NUM_COEFICIENTES_DEF,
    parameter int BITS_INDICE      = BITS_INDICE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   limpiar_i,
    input  logic                   habilitar_i,
    output logic [BITS_INDICE-1:0] indice_o,
    output logic                   fin_cuenta_o
);

    localparam logic [BITS_INDICE-1:0] ULTIMO = BITS_INDICE'(NUM_COEFICIENTES - 1);

    logic [BITS_INDICE-1:0] indice_q;
    logic [BITS_INDICE-1:0] indice_d;

    assign fin_cuenta_o = (indice_q == ULTIMO);
    assign indice_o     = indice_q;

    // Returning to 0 after the last tap keeps the index out of unused addresses.
    always_comb begin
        indice_d = indice_q;
        if (limpiar_i) begin
            indice_d = '0;
        end else if (habilitar_i) begin
            indice_d = fin_cuenta_o ? '0 : indice_q + BITS_INDICE'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            indice_q <= '0;
        end else begin
            indice_q <= indice_d;
        end
    end

endmodule

// File: rtl/controlador_fir.sv
// FIR sequencing controller: clear, NUM_COEFICIENTES MAC cycles, then hold the result until taken.
module controlador_fir
    import filtros_defs::*;
#(
    parameter int NUM_COEFICIENTES = NUM_COEFICIENTES_DEF,
    parameter int BITS_INDICE      = BITS_INDICE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   muestra_valida,
    output logic                   muestra_lista,
    output logic                   desplazar_linea,
    output logic                   limpiar_acumulador,
    output logic                   habilitar_mac,
    output logic [BITS_INDICE-1:0] direccion_coef,
    output logic                   resultado_valido,
    input  logic                   resultado_aceptado,
    output logic                   muestra_perdida,
    output logic [1:0]             estado_o
);

    estado_t                estado_q;
    logic                   valido_q;
    logic                   perdida_q;
    logic                   listo_q;
    logic [BITS_INDICE-1:0] indice;
    logic                   fin_cuenta;

    contador_indice #(
        .NUM_COEFICIENTES (NUM_COEFICIENTES),
        .BITS_INDICE      (BITS_INDICE)
    ) u_indice (
        .clk          (clk),
        .reset        (reset),
        .limpiar_i    (estado_q == LIMPIAR),
        .habilitar_i  (estado_q == ACUMULAR),
        .indice_o     (indice),
        .fin_cuenta_o (fin_cuenta)
    );

    // listo_q keeps muestra_lista low while reset is held and raises it on the first edge after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= ESPERA;
            valido_q  <= 1'b0;
            perdida_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            listo_q   <= 1'b1;
            perdida_q <= muestra_valida && (estado_q != ESPERA);
            case (estado_q)
                ESPERA: begin
                    if (muestra_valida && listo_q) begin
                        estado_q <= LIMPIAR;
                    end
                end
                LIMPIAR: begin
                    estado_q <= ACUMULAR;
                end
                ACUMULAR: begin
                    if (fin_cuenta) begin
                        estado_q <= ENTREGAR;
                    end
                end
                ENTREGAR: begin
                    // One settling cycle for the final product before the result is offered.
                    if (valido_q && resultado_aceptado) begin
                        estado_q <= ESPERA;
                        valido_q <= 1'b0;
                    end else begin
                        valido_q <= 1'b1;
                    end
                end
                default: begin
                    estado_q <= ESPERA;
                end
            endcase
        end
    end

    assign muestra_lista      = listo_q && (estado_q == ESPERA);
    assign desplazar_linea    = (estado_q == LIMPIAR);
    assign limpiar_acumulador = (estado_q == LIMPIAR);
    assign habilitar_mac      = (estado_q == ACUMULAR);
    assign direccion_coef     = (estado_q == ACUMULAR) ? indice : '0;
    assign resultado_valido   = valido_q;
    assign muestra_perdida    = perdida_q;
    assign estado_o           = estado_q;

endmodule
